// File: rtl/skew_buffer.sv
// Input-staging skew/deskew buffer for the systolic array edges: lane i is delayed
// by i (skew) or LANES-1-i (deskew) cycles. Optional SKEW_ZERO_FILL_EN zeroes invalid lanes.

module skew_buffer_lane #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 32,
  parameter int SEL_W  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              vld_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic [SEL_W-1:0]  tap_i,
  output logic              vld_o,
  output logic [DATA_W-1:0] data_o
);

  logic [DEPTH-1:0]             vld_q;
  logic [DEPTH-1:0][DATA_W-1:0] data_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q  <= '0;
      data_q <= '0;
    end else if (en) begin
      vld_q  <= {vld_q[DEPTH-2:0], vld_i};
      data_q <= {data_q[DEPTH-2:0], data_i};
    end
  end

  assign vld_o  = vld_q[tap_i];
  assign data_o = data_q[tap_i];

endmodule

module skew_buffer #(
  parameter int LANES  = 4,
  parameter int DATA_W = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    mode,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [LANES*DATA_W-1:0] in_data,
  output logic [LANES-1:0]        out_valid,
  output logic [LANES*DATA_W-1:0] out_data,
  output logic                    busy,
  output logic                    done
);

  localparam int CNT_W = $clog2(LANES + 1);
  localparam int SEL_W = $clog2(LANES);

  if (LANES < 2) begin : g_bad_lanes
    $error("skew_buffer: LANES must be >= 2");
  end

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             active_mode_q, active_mode_d;
  logic             done_q, done_d;
  logic             acc;

  assign busy     = (cnt_q != '0);
  // Direction changes wait for the pipe to drain so taps never mix modes.
  assign in_ready = !busy | (mode == active_mode_q);
  assign acc      = in_valid & in_ready & en;
  assign done     = done_q;

  always_comb begin
    cnt_d         = cnt_q;
    active_mode_d = active_mode_q;
    done_d        = 1'b0;
    if (acc) begin
      cnt_d = CNT_W'(LANES);
      if (!busy) active_mode_d = mode;
    end else if (en && busy) begin
      cnt_d  = cnt_q - CNT_W'(1);
      done_d = (cnt_q == CNT_W'(1));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q         <= '0;
      active_mode_q <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      cnt_q         <= cnt_d;
      active_mode_q <= active_mode_d;
      done_q        <= done_d;
    end
  end

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    localparam logic [SEL_W-1:0] TAP_SKW = SEL_W'(i);
    localparam logic [SEL_W-1:0] TAP_DSK = SEL_W'(LANES - 1 - i);

    logic              vld;
    logic [DATA_W-1:0] data;

    skew_buffer_lane #(
      .DEPTH  (LANES),
      .DATA_W (DATA_W),
      .SEL_W  (SEL_W)
    ) u_lane (
      .clk    (clk),
      .rst    (rst),
      .en     (en),
      .vld_i  (acc),
      .data_i (in_data[i*DATA_W +: DATA_W]),
      .tap_i  (active_mode_q ? TAP_DSK : TAP_SKW),
      .vld_o  (vld),
      .data_o (data)
    );

    assign out_valid[i] = vld;
`ifdef SKEW_ZERO_FILL_EN
    assign out_data[i*DATA_W +: DATA_W] = vld ? data : '0;
`else
    assign out_data[i*DATA_W +: DATA_W] = data;
`endif
  end

endmodule

// File: tb/tb_skew_buffer.sv
// Self-checking bench for skew_buffer: directed scenarios plus random traffic,
// checked against a beat-history model indexed by enabled-edge count.

module tb_skew_buffer;

  localparam int LANES  = 4;
  localparam int DATA_W = 32;
  localparam int LW     = LANES * DATA_W;

  logic             clk = 1'b0;
  logic             rst, en, mode, in_valid;
  logic [LW-1:0]    in_data;
  logic             in_ready, busy, done;
  logic [LANES-1:0] out_valid;
  logic [LW-1:0]    out_data;

  skew_buffer #(.LANES(LANES), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_data(out_data), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  // Model: n counts enabled edges; a beat accepted at edge n is seen on lane i
  // while the edge count equals n + delay(i).
  int            n     = 0;
  int            last  = -100;
  bit            amode = 1'b0;
  bit            mdone = 1'b0;
  bit            hist_v [int];
  logic [LW-1:0] hist_d [int];

  function automatic bit mbusy();
    return (n - last) < LANES;
  endfunction

  function automatic bit mready(input bit m);
    return !mbusy() || (m == amode);
  endfunction

  task automatic model_reset();
    last  = n - 100;
    amode = 1'b0;
    mdone = 1'b0;
    hist_v.delete();
    hist_d.delete();
  endtask

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    logic [LW-1:0] w;
    chk("busy", 64'(busy), 64'(mbusy()));
    chk("done", 64'(done), 64'(mdone));
    chk("in_ready", 64'(in_ready), 64'(mready(mode)));
    for (int i = 0; i < LANES; i++) begin
      int dly = amode ? (LANES - 1 - i) : i;
      int src = n - dly;
      bit v   = hist_v.exists(src);
      chk($sformatf("out_valid[%0d]", i), 64'(out_valid[i]), 64'(v));
      if (v) begin
        w = hist_d[src];
        chk($sformatf("out_data[%0d]", i), 64'(out_data[i*DATA_W +: DATA_W]),
            64'(w[i*DATA_W +: DATA_W]));
      end
`ifdef SKEW_ZERO_FILL_EN
      else chk($sformatf("zero_fill[%0d]", i), 64'(out_data[i*DATA_W +: DATA_W]), 64'd0);
`endif
    end
  endtask

  // One clock: drive inputs mid-cycle, advance the model on the edge, compare after it.
  task automatic cycle(input logic e, input logic m, input logic v, input logic [LW-1:0] d);
    bit macc, was_busy;
    en = e; mode = m; in_valid = v; in_data = d;
    #1;
    chk("in_ready_pre", 64'(in_ready), 64'(mready(m)));
    macc     = v && e && mready(m);
    was_busy = mbusy();
    @(posedge clk);
    if (e) begin
      n++;
      if (macc) begin
        if (!was_busy) amode = m;
        hist_v[n] = 1'b1;
        hist_d[n] = d;
        last      = n;
      end
      mdone = (n - last) == LANES;
    end else begin
      mdone = 1'b0;
    end
    #1;
    compare_all();
  endtask

  function automatic logic [LW-1:0] rnd_vec();
    logic [LW-1:0] r;
    for (int i = 0; i < LANES; i++) r[i*DATA_W +: DATA_W] = $urandom;
    return r;
  endfunction

  task automatic idle(input int cycles, input logic m);
    for (int k = 0; k < cycles; k++) cycle(1'b1, m, 1'b0, rnd_vec());
  endtask

  task automatic mid_reset();
    #2 rst = 1'b1;
    #1;
    model_reset();
    compare_all();
    @(posedge clk);
    #1 rst = 1'b0;
    compare_all();
  endtask

  logic [DATA_W-1:0] word;
  logic              rmode;

  initial begin
    rst = 1'b0; en = 1'b0; mode = 1'b0; in_valid = 1'b0; in_data = '0;
    #1 rst = 1'b1;
    #2;
    model_reset();
    compare_all();
    for (int i = 0; i < LANES; i++)
      chk($sformatf("reset_data[%0d]", i), 64'(out_data[i*DATA_W +: DATA_W]), 64'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    compare_all();

    // Skew single beat of 5.0 on every lane
    word = 32'h40A00000;
    cycle(1'b1, 1'b0, 1'b1, {LANES{word}});
    idle(8, 1'b0);

    // Deskew, four beats back-to-back
    for (int k = 0; k < 4; k++) begin
      word = 32'h40400000 + 32'(k);
      cycle(1'b1, 1'b1, 1'b1, {LANES{word}});
    end
    idle(8, 1'b1);

    // Stall for 3 cycles right after a skew accept
    word = 32'h40A00000;
    cycle(1'b1, 1'b0, 1'b1, {LANES{word}});
    for (int k = 0; k < 3; k++) cycle(1'b0, 1'b0, 1'b0, rnd_vec());
    idle(8, 1'b0);

    // Direction change requested while busy
    cycle(1'b1, 1'b0, 1'b1, rnd_vec());
    for (int k = 0; k < 6; k++) cycle(1'b1, 1'b1, 1'b1, rnd_vec());
    idle(8, 1'b1);

    // Async reset mid-flight, then normal traffic
    cycle(1'b1, 1'b1, 1'b1, rnd_vec());
    idle(2, 1'b1);
    mid_reset();
    idle(2, 1'b0);
    word = 32'h40A00000;
    cycle(1'b1, 1'b0, 1'b1, {LANES{word}});
    idle(8, 1'b0);

    // Random traffic with stalls, occasional direction flips and a reset
    rmode = 1'b0;
    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(15) == 0) rmode = ~rmode;
      cycle(($urandom_range(4) != 0), rmode, ($urandom_range(2) != 0), rnd_vec());
      if (k == 200) mid_reset();
    end
    idle(8, rmode);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
